// File: rtl/dds_seq_pkg.sv
// Shared definitions for the DDS profile sequencer.
//  - state_t    : sequencer FSM encoding (IDLE/FETCH/LOAD/RUN)
//  - DEF_*      : default widths for the profile fields and table depth
//  - *_LSB      : field offsets inside the packed profile word {dwell, step, cnt}
//                 (at the default widths)
package dds_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam int DEF_N_PROF  = 8;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_STEP_W  = 8;
  localparam int DEF_DWELL_W = 16;

  // Profile word layout: cnt in the low bits, then step, dwell on top.
  localparam int CNT_LSB   = 0;
  localparam int STEP_LSB  = DEF_CNT_W;
  localparam int DWELL_LSB = DEF_CNT_W + DEF_STEP_W;

endpackage

// File: rtl/dds_profile_ram.sv
// Profile table storage: N x W, one write port, one synchronous read port
// (data appears one clock after the address). Contents are not reset.
// Ports:
//  clk    : clock
//  we     : write enable
//  waddr  : write slot
//  wdata  : write word
//  raddr  : read slot
//  rdata  : registered read word
module dds_profile_ram #(
  parameter int N  = 8,
  parameter int W  = 40,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dds_profile_seq.sv
// Profile sequencer for a DDS core. Holds N_PROF profiles {dwell, step, cnt}
// and plays slots 0..n_prof-1 in order, driving dds_cnt/dds_step/dds_clr.
// Each profile costs two clear cycles (FETCH, LOAD) followed by exactly
// max(dwell,1) cycles with dds_clr low.
// Optional build macro: DDS_SEQ_LOOP_EN adds input loop_en; with it high at
// last-slot expiry the sequence restarts at slot 0 instead of finishing.
// Ports:
//  clk, rst            : clock, asynchronous active-low reset
//  cfg_we/addr/wdata   : table write (accepted only while idle)
//  n_prof              : slots to play, sampled on an accepted start
//  start, abort        : sequence control (abort dominates)
//  busy, done, cfg_err : status (done/cfg_err are one-cycle pulses)
//  prof_idx            : slot currently playing
//  dds_cnt/step/clr    : DDS core controls
module dds_profile_seq
  import dds_seq_pkg::*;
#(
  parameter  int N_PROF  = DEF_N_PROF,
  parameter  int CNT_W   = DEF_CNT_W,
  parameter  int STEP_W  = DEF_STEP_W,
  parameter  int DWELL_W = DEF_DWELL_W,
  localparam int AW      = (N_PROF > 1) ? $clog2(N_PROF) : 1,
  localparam int PW      = DWELL_W + STEP_W + CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [PW-1:0]     cfg_wdata,
  input  logic [AW:0]       n_prof,
  input  logic              start,
  input  logic              abort,
`ifdef DDS_SEQ_LOOP_EN
  input  logic              loop_en,
`endif
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [AW-1:0]     prof_idx,
  output logic [CNT_W-1:0]  dds_cnt,
  output logic [STEP_W-1:0] dds_step,
  output logic              dds_clr
);

  // Field offsets for the configured widths (match the package at defaults).
  localparam int STEP_LO  = CNT_W;
  localparam int DWELL_LO = CNT_W + STEP_W;

  state_t               state, nxt;
  logic [AW-1:0]        idx;
  logic [AW:0]          n_lat;
  logic [DWELL_W-1:0]   dwell_cnt;
  logic [PW-1:0]        rd_data;
  logic [DWELL_W-1:0]   rd_dwell;
  logic [AW:0]          idx_inc;
  logic [AW:0]          n_clamp;
  logic                 wr_en, expire, last, loop_on, accept;

`ifdef DDS_SEQ_LOOP_EN
  assign loop_on = loop_en;
`else
  assign loop_on = 1'b0;
`endif

  // Table writes are only honoured while idle; a write in the start cycle
  // lands before FETCH reads, so the sequence sees the new data.
  assign wr_en = cfg_we && (state == S_IDLE);

  dds_profile_ram #(.N(N_PROF), .W(PW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (idx),
    .rdata (rd_data)
  );

  assign rd_dwell = rd_data[DWELL_LO +: DWELL_W];
  assign idx_inc  = {1'b0, idx} + (AW+1)'(1);
  assign last     = (idx_inc >= n_lat);
  // Counter is loaded with max(dwell,1), so the final RUN cycle sees 1.
  assign expire   = (state == S_RUN) && (dwell_cnt == DWELL_W'(1));
  assign accept   = (state == S_IDLE) && start && !abort;
  // Out-of-range requests are limited to the table size so idx never wraps.
  assign n_clamp  = (n_prof > (AW+1)'(N_PROF)) ? (AW+1)'(N_PROF) : n_prof;

  assign busy     = (state != S_IDLE);
  assign dds_clr  = (state != S_RUN);
  assign prof_idx = idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start && (n_prof != '0)) nxt = S_FETCH;
      S_FETCH: nxt = S_LOAD;
      S_LOAD:  nxt = S_RUN;
      S_RUN:   if (expire) nxt = (!last || loop_on) ? S_FETCH : S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (abort) nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      n_lat     <= '0;
      dwell_cnt <= '0;
      dds_cnt   <= '0;
      dds_step  <= '0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= cfg_we && (state != S_IDLE);
      if (accept) begin
        if (n_prof == '0) begin
          done <= 1'b1;
        end else begin
          n_lat <= n_clamp;
          idx   <= '0;
        end
      end
      if ((state == S_LOAD) && !abort) begin
        dds_cnt   <= rd_data[0 +: CNT_W];
        dds_step  <= rd_data[STEP_LO +: STEP_W];
        dwell_cnt <= (rd_dwell == '0) ? DWELL_W'(1) : rd_dwell;
      end
      if ((state == S_RUN) && !abort) begin
        if (expire) begin
          if (!last)        idx  <= idx_inc[AW-1:0];
          else if (loop_on) idx  <= '0;
          else              done <= 1'b1;
        end else begin
          dwell_cnt <= dwell_cnt - DWELL_W'(1);
        end
      end
    end
  end

endmodule
